// File: rtl/servant_ram_pkg.sv
// Shared definitions for the servant latency-configurable RAM: FSM encoding,
// latency bound and byte-parity helper.
package servant_ram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int LAT_MAX = 4;

  // Even parity: stored bit makes the 9-bit group have an even count of ones.
  function automatic logic parity8(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/servant_ram_par.sv
// Per-lane parity: generates parity bits for write data and reduces the
// read-side check of all lanes to a single error flag.
module servant_ram_par
  import servant_ram_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [NB*8-1:0] wdat_i,
  output logic [NB-1:0]   wpar_o,
  input  logic [NB*8-1:0] rdat_i,
  input  logic [NB-1:0]   rpar_i,
  output logic            perr_o
);

  logic [NB-1:0] mis;

  for (genvar g = 0; g < NB; g++) begin : g_lane
    assign wpar_o[g] = parity8(wdat_i[g*8 +: 8]);
    assign mis[g]    = parity8(rdat_i[g*8 +: 8]) ^ rpar_i[g];
  end

  assign perr_o = |mis;

endmodule

// File: rtl/servant_ram_lat.sv
// Single-port Wishbone RAM with configurable width, depth and ack latency.
// Define SERVANT_RAM_PARITY_EN to store per-byte parity and flag read errors.
module servant_ram_lat
  import servant_ram_pkg::*;
#(
  parameter int dw      = 32,
  parameter int depth   = 256,
  parameter int lat     = 1,
  parameter     memfile = ""
) (
  input  logic                                        i_wb_clk,
  input  logic                                        i_wb_rst,
  input  logic [$clog2(depth)-1:$clog2(dw/8)]         i_wb_adr,
  input  logic [dw-1:0]                               i_wb_dat,
  input  logic [dw/8-1:0]                             i_wb_sel,
  input  logic                                        i_wb_we,
  input  logic                                        i_wb_cyc,
  output logic [dw-1:0]                               o_wb_rdt,
  output logic                                        o_wb_ack,
  output logic                                        o_wb_err
);

  localparam int NB    = dw / 8;
  localparam int WORDS = depth / NB;

  logic [dw-1:0] mem [WORDS];

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          we_q;
  logic [dw-1:0] rd_q, rd_word, rd_src;
  logic [dw-1:0] rdt_q;
  logic          ack_q, err_q;
  logic          accept, fin, is_rd, perr;

  assign accept  = (state_q == ST_IDLE) && i_wb_cyc;
  assign rd_word = mem[i_wb_adr];
  // With lat=1 the ack edge is the acceptance edge, so bypass the capture stage.
  assign rd_src  = (lat == 1) ? rd_word : rd_q;
  assign is_rd   = (lat == 1) ? !i_wb_we : !we_q;
  assign fin     = (state_d == ST_DONE) && (state_q != ST_DONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (i_wb_cyc) begin
        cnt_d   = 3'd1;
        state_d = (lat == 1) ? ST_DONE : ST_BUSY;
      end
      ST_BUSY: begin
        if (!i_wb_cyc) begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end else if (cnt_q == 3'(lat - 1)) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

`ifdef SERVANT_RAM_PARITY_EN
  logic [NB-1:0] par_q [WORDS];
  logic [NB-1:0] rpar_q, wpar;

  servant_ram_par #(.NB(NB)) u_par (
    .wdat_i (i_wb_dat),
    .wpar_o (wpar),
    .rdat_i (rd_src),
    .rpar_i ((lat == 1) ? par_q[i_wb_adr] : rpar_q),
    .perr_o (perr)
  );

  always_ff @(posedge i_wb_clk) begin
    if (!i_wb_rst && accept) begin
      rpar_q <= par_q[i_wb_adr];
      if (i_wb_we)
        for (int i = 0; i < NB; i++)
          if (i_wb_sel[i]) par_q[i_wb_adr][i] <= wpar[i];
    end
  end
`else
  assign perr = 1'b0;
`endif

  // Storage is never reset; writes commit on the acceptance edge.
  always_ff @(posedge i_wb_clk) begin
    if (!i_wb_rst && accept && i_wb_we)
      for (int i = 0; i < NB; i++)
        if (i_wb_sel[i]) mem[i_wb_adr][i*8 +: 8] <= i_wb_dat[i*8 +: 8];
  end

  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      we_q    <= 1'b0;
      rd_q    <= '0;
      rdt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= fin && !(is_rd && perr);
      err_q   <= fin && is_rd && perr;
      if (fin && is_rd) rdt_q <= rd_src;
      if (accept) begin
        we_q <= i_wb_we;
        rd_q <= rd_word;
      end
    end
  end

  assign o_wb_rdt = rdt_q;
  assign o_wb_ack = ack_q;
  assign o_wb_err = err_q;

endmodule

// File: tb/tb_servant_ram_lat.sv
// Bench for servant_ram_lat: one dw=32/lat=1 instance plus dw=64 instances
// for lat=1..4, checked against a byte-array reference model.
module tb_servant_ram_lat;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [4:0][63:0]     dat;
  logic [4:0][7:0]      sel, adr;
  logic [4:0]           we, cyc, ack, err;
  logic [31:0]          rdt0;
  logic [4:1][63:0]     rdt64;

  int nvec = 0;
  int nbad = 0;

  logic [7:0] mm [5][256];

  servant_ram_lat #(.dw(32), .depth(256), .lat(1)) u_dut32 (
    .i_wb_clk(clk), .i_wb_rst(rst), .i_wb_adr(adr[0][5:0]), .i_wb_dat(dat[0][31:0]),
    .i_wb_sel(sel[0][3:0]), .i_wb_we(we[0]), .i_wb_cyc(cyc[0]),
    .o_wb_rdt(rdt0), .o_wb_ack(ack[0]), .o_wb_err(err[0])
  );

  for (genvar g = 1; g <= 4; g++) begin : g_d64
    servant_ram_lat #(.dw(64), .depth(256), .lat(g)) u_dut (
      .i_wb_clk(clk), .i_wb_rst(rst), .i_wb_adr(adr[g][4:0]), .i_wb_dat(dat[g]),
      .i_wb_sel(sel[g]), .i_wb_we(we[g]), .i_wb_cyc(cyc[g]),
      .o_wb_rdt(rdt64[g]), .o_wb_ack(ack[g]), .o_wb_err(err[g])
    );
  end

  function automatic int nbytes(input int k);
    return (k == 0) ? 4 : 8;
  endfunction

  function automatic int latk(input int k);
    return (k == 0) ? 1 : k;
  endfunction

  function automatic logic [63:0] get_rdt(input int k);
    return (k == 0) ? {32'h0, rdt0} : rdt64[k];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic mwr(input int k, input int a, input logic [63:0] d, input logic [7:0] s);
    for (int i = 0; i < nbytes(k); i++)
      if (s[i]) mm[k][(a * nbytes(k) + i) % 256] = d[i*8 +: 8];
  endtask

  function automatic logic [63:0] mrd(input int k, input int a);
    logic [63:0] r = '0;
    for (int i = 0; i < nbytes(k); i++) r[i*8 +: 8] = mm[k][(a * nbytes(k) + i) % 256];
    return r;
  endfunction

  // One request on instance k; n = negedges from request to ack/err, 0 = timeout.
  task automatic xfer(input int k, input bit w, input logic [7:0] a, input logic [63:0] d,
                      input logic [7:0] s, output logic [63:0] r, output bit ak,
                      output bit er, output int n);
    @(negedge clk);
    we[k] = w; adr[k] = a; dat[k] = d; sel[k] = s; cyc[k] = 1'b1;
    n = 0; ak = 1'b0; er = 1'b0; r = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ack[k] || err[k]) begin
        n = i; ak = ack[k]; er = err[k]; r = get_rdt(k);
        break;
      end
    end
    cyc[k] = 1'b0;
  endtask

  typedef struct {
    bit          w;
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] r, m, ex;
    bit ak, er;
    int n, seen;
    int acnt [5];

    rst = 1'b1; dat = '0; sel = '0; adr = '0; we = '0; cyc = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rst_rdt%0d", k), get_rdt(k), 64'h0);
      chk($sformatf("rst_ackerr%0d", k), {62'h0, ack[k], err[k]}, 64'h0);
    end

    tbl[0] = '{1'b1, 8'd5, 32'hDEADBEEF, 4'hF, 32'h0};
    tbl[1] = '{1'b0, 8'd5, 32'h0,        4'h0, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 8'd6, 32'hFFFFFFFF, 4'hF, 32'h0};
    tbl[3] = '{1'b1, 8'd6, 32'h11223344, 4'h5, 32'h0};
    tbl[4] = '{1'b0, 8'd6, 32'h0,        4'h0, 32'hFF22FF44};
    tbl[5] = '{1'b1, 8'd5, 32'h00000000, 4'h0, 32'h0};
    tbl[6] = '{1'b0, 8'd5, 32'h0,        4'h0, 32'hDEADBEEF};
    tbl[7] = '{1'b1, 8'd6, 32'hAABBCCDD, 4'hA, 32'h0};
    tbl[8] = '{1'b0, 8'd6, 32'h0,        4'h0, 32'hAA22CC44};
    for (int i = 0; i < 9; i++) begin
      xfer(0, tbl[i].w, tbl[i].a, {32'h0, tbl[i].d}, {4'h0, tbl[i].s}, r, ak, er, n);
      chk($sformatf("tbl%0d_lat", i), 64'(n), 64'd1);
      chk($sformatf("tbl%0d_ackerr", i), {62'h0, ak, er}, 64'h2);
      if (!tbl[i].w) chk($sformatf("tbl%0d_rdt", i), r, {32'h0, tbl[i].exp});
      if (tbl[i].w) mwr(0, tbl[i].a, {32'h0, tbl[i].d}, {4'h0, tbl[i].s});
    end

    // Parity path: corrupt lane-0 parity of word 20 when parity storage exists.
    xfer(0, 1'b1, 8'd20, 64'h1, 8'hF, r, ak, er, n);
`ifdef SERVANT_RAM_PARITY_EN
    u_dut32.par_q[20][0] = ~u_dut32.par_q[20][0];
    xfer(0, 1'b0, 8'd20, 64'h0, 8'h0, r, ak, er, n);
    chk("par_ackerr", {62'h0, ak, er}, 64'h1);
`else
    xfer(0, 1'b0, 8'd20, 64'h0, 8'h0, r, ak, er, n);
    chk("par_ackerr", {62'h0, ak, er}, 64'h2);
`endif
    chk("par_rdt", r, 64'h1);
    chk("par_lat", 64'(n), 64'd1);

    for (int k = 0; k < 5; k++)
      for (int a = 0; a < 10; a++) begin
        m = {$urandom, $urandom};
        xfer(k, 1'b1, 8'(a), m, 8'hFF, r, ak, er, n);
        mwr(k, a, m, 8'hFF);
      end

    for (int k = 0; k < 5; k++)
      for (int t = 0; t < 40; t++) begin
        bit w = 1'($urandom);
        logic [7:0] a = 8'($urandom_range(0, 7));
        logic [7:0] s = 8'($urandom);
        m = {$urandom, $urandom};
        xfer(k, w, a, m, s, r, ak, er, n);
        chk($sformatf("rnd%0d_%0d_lat", k, t), 64'(n), 64'(latk(k)));
        chk($sformatf("rnd%0d_%0d_ackerr", k, t), {62'h0, ak, er}, 64'h2);
        if (w) mwr(k, a, m, s);
        else chk($sformatf("rnd%0d_%0d_rdt", k, t), r, mrd(k, a));
      end

    // Throughput: cyc held 10 cycles on all dw=64 instances at once.
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      we[k] = 1'b0; adr[k] = 8'd0; cyc[k] = 1'b1; acnt[k] = 0;
    end
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      for (int k = 1; k <= 4; k++) if (ack[k]) acnt[k]++;
      if (i == 10) for (int k = 1; k <= 4; k++) cyc[k] = 1'b0;
    end
    for (int k = 1; k <= 4; k++)
      chk($sformatf("thru_lat%0d", k), 64'(acnt[k]), 64'(10 / (k + 1)));

    // Reset mid-BUSY on lat=3: the pending ack must never appear.
    xfer(3, 1'b0, 8'd0, 64'h0, 8'h0, r, ak, er, n);
    chk("pre_rst_rdt", r, mrd(3, 0));
    @(negedge clk);
    we[3] = 1'b0; adr[3] = 8'd1; cyc[3] = 1'b1;
    @(negedge clk);
    rst = 1'b1; cyc[3] = 1'b0;
    seen = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (ack[3] || err[3]) seen++;
      if (i == 2) rst = 1'b0;
    end
    chk("rst_noack", 64'(seen), 64'd0);
    chk("rst_rdt_after", rdt64[3], 64'h0);

    // Abort on lat=4: write committed, no ack.
    @(negedge clk);
    we[4] = 1'b1; adr[4] = 8'd9; dat[4] = 64'hA5; sel[4] = 8'h01; cyc[4] = 1'b1;
    seen = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (ack[4] || err[4]) seen++;
      if (i == 2) cyc[4] = 1'b0;
    end
    chk("abort_noack", 64'(seen), 64'd0);
    mwr(4, 9, 64'hA5, 8'h01);
    xfer(4, 1'b0, 8'd9, 64'h0, 8'h0, r, ak, er, n);
    chk("abort_lat", 64'(n), 64'd4);
    chk("abort_byte", {56'h0, r[7:0]}, 64'hA5);
    ex = mrd(4, 9);
    chk("abort_word", r, ex);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
